// File: rtl/alarm_ctrl_pkg.sv
// rtl/alarm_ctrl_pkg.sv - shared state type, tick constants and state-to-LED mapping
package alarm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_t;

  // The tick clock runs at 2 Hz.
  localparam int TICKS_PER_MIN = 120;

  localparam logic [1:0] LED_IDLE    = 2'd0;
  localparam logic [1:0] LED_ARMED   = 2'd1;
  localparam logic [1:0] LED_RINGING = 2'd2;
  localparam logic [1:0] LED_SNOOZE  = 2'd3;

  function automatic logic [1:0] state_led(alarm_state_t s);
    case (s)
      IDLE:    return LED_IDLE;
      ARMED:   return LED_ARMED;
      RINGING: return LED_RINGING;
      SNOOZE:  return LED_SNOOZE;
      default: return LED_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/key_edge_det.sv
// rtl/key_edge_det.sv - samples an active-low key and pulses for one tick on its press
module key_edge_det (
  input  logic clkout1,
  input  logic reset,
  input  logic key_n,
  output logic pulse
);

  logic sync_q;
  logic prev_q;

  // Released level is 1, so a key already down at reset release still yields one pulse.
  always_ff @(posedge clkout1 or posedge reset) begin
    if (reset) begin
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= key_n;
      prev_q <= sync_q;
    end
  end

  assign pulse = prev_q & ~sync_q;

endmodule

// File: rtl/alarm_ring_controller.sv
// rtl/alarm_ring_controller.sv - alarm trigger, ring/snooze/dismiss sequencing and 1 Hz blink
module alarm_ring_controller #(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_TICKS = 120,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clkout1,
  input  logic       reset,
  input  logic       activatealarm,
  input  logic       run_clock,
  input  logic       key_dismiss_n,
  input  logic       key_snooze_n,
  input  logic [7:0] hrs,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic [7:0] hrs_alrm,
  input  logic [7:0] min_alrm,
  output logic       ringing,
  output logic       led_flash,
  output logic       snoozing,
  output logic [2:0] snooze_cnt,
  output logic [1:0] state_o
);
  import alarm_ctrl_pkg::*;

  localparam int SNZ_TICKS = SNOOZE_MIN * TICKS_PER_MIN;
  localparam int RW = $clog2(RING_TICKS);
  localparam int SW = $clog2(SNZ_TICKS);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_TICKS - 1);
  localparam logic [SW-1:0] SNZ_LAST  = SW'(SNZ_TICKS - 1);
  localparam logic [2:0]    SNZ_MAX   = 3'(MAX_SNOOZE);

  alarm_state_t  state, state_next;
  logic [RW-1:0] ring_tmr, ring_next;
  logic [SW-1:0] snz_tmr, snz_next;
  logic [2:0]    scnt, scnt_next;
  logic          match, match_q, trig;
  logic          dismiss, snooze;

  key_edge_det u_key_dismiss (
    .clkout1 (clkout1),
    .reset   (reset),
    .key_n   (key_dismiss_n),
    .pulse   (dismiss)
  );

  key_edge_det u_key_snooze (
    .clkout1 (clkout1),
    .reset   (reset),
    .key_n   (key_snooze_n),
    .pulse   (snooze)
  );

  // sec==0 holds for two ticks; the edge compare makes it a single trigger.
  assign match = (hrs == hrs_alrm) && (min == min_alrm) && (sec == 8'd0) && run_clock;
  assign trig  = match && !match_q;

  always_comb begin
    state_next = state;
    ring_next  = ring_tmr;
    snz_next   = snz_tmr;
    scnt_next  = scnt;
    if (!activatealarm) begin
      state_next = IDLE;
      ring_next  = '0;
      snz_next   = '0;
      scnt_next  = '0;
    end else begin
      case (state)
        IDLE: state_next = ARMED;
        ARMED: begin
          if (trig) begin
            state_next = RINGING;
            ring_next  = '0;
            scnt_next  = '0;
          end
        end
        RINGING: begin
          if (dismiss || ring_tmr == RING_LAST) begin
            state_next = ARMED;
          end else if (snooze && scnt < SNZ_MAX) begin
            state_next = SNOOZE;
            scnt_next  = scnt + 3'd1;
            snz_next   = '0;
          end else begin
            ring_next = ring_tmr + RW'(1);
          end
        end
        SNOOZE: begin
          if (dismiss) begin
            state_next = ARMED;
          end else if (run_clock) begin
            if (snz_tmr == SNZ_LAST) begin
              state_next = RINGING;
              ring_next  = '0;
            end else begin
              snz_next = snz_tmr + SW'(1);
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clkout1 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clkout1 or posedge reset) begin
    if (reset) begin
      ring_tmr <= '0;
      snz_tmr  <= '0;
      scnt     <= '0;
      match_q  <= 1'b0;
    end else begin
      ring_tmr <= ring_next;
      snz_tmr  <= snz_next;
      scnt     <= scnt_next;
      match_q  <= match;
    end
  end

  // Outputs decode the settled state, so they trail the state register by one tick.
  always_ff @(posedge clkout1 or posedge reset) begin
    if (reset) begin
      ringing    <= 1'b0;
      led_flash  <= 1'b0;
      snoozing   <= 1'b0;
      snooze_cnt <= 3'd0;
      state_o    <= LED_IDLE;
    end else begin
      ringing    <= (state == RINGING);
      led_flash  <= (state == RINGING) ? ~led_flash : 1'b0;
      snoozing   <= (state == SNOOZE);
      snooze_cnt <= scnt;
      state_o    <= state_led(state);
    end
  end

endmodule
